seq_normalizer: RTL and testbench
=================================

SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 SHALL have parameter N, default 3, giving a data width of 2**N bits and a shift-count width of N bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: requests normalization of in; sampled only in IDLE.
REQ-005 SHALL have port in, input, 2**N bits: operand, captured on the edge that accepts start.
REQ-006 SHALL have port lr, input, 1 bit: direction, captured with in; 1 = normalize left (count leading zeros), 0 = normalize right (count trailing zeros).
REQ-007 SHALL have port out, output, 2**N bits: normalized operand.
REQ-008 SHALL have port amt, output, N bits: number of single-bit shifts applied.
REQ-009 SHALL have port zero, output, 1 bit: captured operand was all zeros.
REQ-010 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when out, amt and zero become valid.

Function
REQ-012 SHALL implement three states:
- IDLE: waiting for start.
- SHIFT: shifting one bit per cycle.
- DONE: one-cycle result-valid state.
REQ-013 In IDLE, SHALL accept start=1 on an edge by:
- latching in to a working register and lr to a direction register;
- clearing the shift counter;
- entering SHIFT.
REQ-014 In IDLE with start=0, SHALL remain in IDLE and hold all outputs.
REQ-015 In SHIFT, on each edge, SHALL apply the first matching rule:
- working register all zeros: zero<=1, amt<=0, out<=0, go to DONE;
- target bit set (bit 2**N-1 when lr=1, bit 0 when lr=0): out<=working register, amt<=counter, zero<=0, go to DONE;
- otherwise: shift the working register one bit toward the target bit, zero-filling the vacated bit, and increment the counter.
REQ-016 The counter SHALL never exceed 2**N-1, so that it fits in N bits without wrap-around.
REQ-017 SHALL assert done only in DONE, for exactly one cycle, and then return to IDLE unconditionally.
REQ-018 SHALL assert busy in SHIFT only; busy SHALL be 0 in IDLE and DONE.
REQ-019 SHALL ignore start while in SHIFT or DONE, with no effect on the operation in progress and no queuing.
REQ-020 SHALL ignore changes on in and lr after capture.
REQ-021 SHALL hold out, amt and zero from DONE until the next result is written; they SHALL NOT change during a subsequent SHIFT phase.
REQ-022 Latency: with start accepted at edge k and z shifts required (z=0 for a zero operand or a target bit already set), done SHALL be high in the cycle following edge k+1+z.
REQ-023 Maximum latency SHALL be 2**N cycles from the accepting edge to done (operand with only the far bit set).

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear out, amt, zero, busy, done and all internal registers to 0, overriding start.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation: no done pulse, and outputs cleared on that edge.
REQ-026 The first start after rst deasserts SHALL be accepted normally.

Verification (N=3)
REQ-027 in=8'b0001_0110, lr=1, start pulse -> busy for 4 cycles; then done with out=8'b1011_0000, amt=3, zero=0.
REQ-028 in=8'b0001_0110, lr=0 -> done after 2 busy cycles, with out=8'b0000_1011, amt=1, zero=0.
REQ-029 Boundary operands:
- in=8'h00, either lr -> done after 1 busy cycle, zero=1, amt=0, out=0;
- in=8'h80, lr=1 -> amt=0 after 1 busy cycle;
- in=8'h01, lr=1 -> amt=7, out=8'h80 after 8 busy cycles.
REQ-030 in=8'h01, lr=1; start re-pulsed with in=8'hFF during SHIFT -> ignored; result is still amt=7.
REQ-031 in=8'h01, lr=1; rst asserted 3 cycles after start -> no done pulse, all outputs 0; a new start with in=8'h40, lr=1 -> amt=1, out=8'h80.

Source files
------------

// File: rtl/seq_normalizer.sv
// Sequential normalizer: shifts the operand one bit per cycle toward the
// selected end until the target bit is set, reporting the shift count.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - request normalization (sampled only in IDLE)
//   in    - operand, 2**N bits, captured when start is accepted
//   lr    - direction, 1 = left (leading zeros), 0 = right (trailing zeros)
//   out   - normalized operand
//   amt   - number of single-bit shifts applied
//   zero  - captured operand was all zeros
//   busy  - high while shifting
//   done  - one-cycle pulse when out/amt/zero are valid
module seq_normalizer #(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2**N-1:0]  in,
   input  logic             lr,
   output logic [2**N-1:0]  out,
   output logic [N-1:0]     amt,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int W = 2**N;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   work, work_n;
   logic           dir, dir_n;
   logic [N-1:0]   cnt, cnt_n;
   logic [W-1:0]   out_r, out_n;
   logic [N-1:0]   amt_r, amt_n;
   logic           zero_r, zero_n;
   logic           target;

   // Bit that must end up set: MSB for left, LSB for right.
   assign target = dir ? work[W-1] : work[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         work   <= '0;
         dir    <= 1'b0;
         cnt    <= '0;
         out_r  <= '0;
         amt_r  <= '0;
         zero_r <= 1'b0;
      end else begin
         state  <= state_n;
         work   <= work_n;
         dir    <= dir_n;
         cnt    <= cnt_n;
         out_r  <= out_n;
         amt_r  <= amt_n;
         zero_r <= zero_n;
      end
   end

   always_comb begin
      state_n = state;
      work_n  = work;
      dir_n   = dir;
      cnt_n   = cnt;
      out_n   = out_r;
      amt_n   = amt_r;
      zero_n  = zero_r;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               work_n  = in;
               dir_n   = lr;
               cnt_n   = '0;
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (work == '0) begin
               zero_n  = 1'b1;
               amt_n   = '0;
               out_n   = '0;
               state_n = S_DONE;
            end else if (target) begin
               out_n   = work;
               amt_n   = cnt;
               zero_n  = 1'b0;
               state_n = S_DONE;
            end else begin
               // A nonzero operand reaches the target within W-1 shifts,
               // so the counter cannot pass W-1.
               if (dir) begin
                  work_n = {work[W-2:0], 1'b0};
               end else begin
                  work_n = {1'b0, work[W-1:1]};
               end
               cnt_n = cnt + 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign out  = out_r;
   assign amt  = amt_r;
   assign zero = zero_r;
   assign busy = (state == S_SHIFT);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer (N=3): the driver queues the
// expected result per operation, the monitor checks each done pulse.
module tb_seq_normalizer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] din;
   logic       lr;
   logic [7:0] dout;
   logic [2:0] amt;
   logic       zero;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] o;
      logic [2:0] a;
      logic       z;
      int         b;
   } exp_t;

   exp_t q[$];

   logic [7:0] hold_o;
   logic [2:0] hold_a;
   logic       hold_z;
   int         busy_cnt;

   seq_normalizer #(.N(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in    (din),
      .lr    (lr),
      .out   (dout),
      .amt   (amt),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: outputs must hold during SHIFT; each done pops one result.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
         hold_o   = '0;
         hold_a   = '0;
         hold_z   = 1'b0;
      end else begin
         if (busy) begin
            busy_cnt++;
            chk("hold_out", int'(dout), int'(hold_o));
            chk("hold_amt", int'(amt), int'(hold_a));
            chk("hold_zero", int'(zero), int'(hold_z));
         end
         if (done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("out", int'(dout), int'(e.o));
               chk("amt", int'(amt), int'(e.a));
               chk("zero", int'(zero), int'(e.z));
               chk("busy_cycles", busy_cnt, e.b);
               chk("busy_in_done", int'(busy), 0);
               hold_o = e.o;
               hold_a = e.a;
               hold_z = e.z;
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_done(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s actual=no_done required=done", name);
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [7:0] v, input logic d,
                      input logic [7:0] eo, input logic [2:0] ea,
                      input logic ez, input int eb);
      exp_t e;
      e.o = eo;
      e.a = ea;
      e.z = ez;
      e.b = eb;
      q.push_back(e);
      start = 1'b1;
      din   = v;
      lr    = d;
      @(negedge clk);
      start = 1'b0;
      din   = 8'h5A;
      lr    = ~d;
      wait_done("run");
   endtask

   initial begin
      exp_t e;
      rst   = 1'b1;
      start = 1'b1;
      din   = 8'hFF;
      lr    = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out", int'(dout), 0);
      chk("rst_amt", int'(amt), 0);
      chk("rst_zero", int'(zero), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);

      run(8'h16, 1'b1, 8'hB0, 3'd3, 1'b0, 4);
      run(8'h16, 1'b0, 8'h0B, 3'd1, 1'b0, 2);
      run(8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1);
      run(8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1);
      run(8'h80, 1'b1, 8'h80, 3'd0, 1'b0, 1);
      run(8'h01, 1'b1, 8'h80, 3'd7, 1'b0, 8);
      run(8'h01, 1'b0, 8'h01, 3'd0, 1'b0, 1);
      run(8'h80, 1'b0, 8'h01, 3'd7, 1'b0, 8);
      run(8'h28, 1'b0, 8'h05, 3'd3, 1'b0, 4);

      // Start re-pulsed mid-SHIFT with a different operand/direction.
      e.o = 8'h80;
      e.a = 3'd7;
      e.z = 1'b0;
      e.b = 8;
      q.push_back(e);
      start = 1'b1;
      din   = 8'h01;
      lr    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      din   = 8'hFF;
      lr    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore_start");

      // Reset mid-SHIFT aborts without a done pulse.
      start = 1'b1;
      din   = 8'h01;
      lr    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_out", int'(dout), 0);
      chk("abort_amt", int'(amt), 0);
      chk("abort_zero", int'(zero), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      run(8'h40, 1'b1, 8'h80, 3'd1, 1'b0, 2);

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
